// File: rtl/ula_pkg.sv
// Shared definitions for the ULA arbiter: op codes, legality check and FSM states.
package ula_pkg;

  localparam int WIDTH = 9;
  localparam int OPW   = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_NOR, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: when both request, the one not granted last wins.
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       any_o
);

  assign any_o   = |valid_i;
  assign grant_o = (&valid_i) ? ~last_i : valid_i[1];

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ULA between two requesters: accept in IDLE, drive the ULA in EXEC,
// hold the registered result in RESP until the granted requester takes it.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic               busy,
  output logic [WIDTH-1:0]   ula_a,
  output logic [WIDTH-1:0]   ula_b,
  output logic [OPW-1:0]     ula_ctrl,
  input  logic [WIDTH-1:0]   ula_result,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Requesters hold valid/payload until req_ready; the response holds until rsp_ready.

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             pick, pick_any;

  rr_pick2 u_pick (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (pick),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    data_d    = data_q;
    zero_d    = zero_q;
    err_d     = err_q;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst so outputs read 0 for the whole reset pulse.
        if (pick_any && !rst) begin
          req_ready = pick ? 2'b10 : 2'b01;
          grant_d   = pick;
          a_d       = pick ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
          b_d       = pick ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
          op_d      = pick ? req_op[OPW +: OPW]   : req_op[0 +: OPW];
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_legal(op_q)) begin
          data_d = ula_result;
          zero_d = (ula_result == '0);
          err_d  = 1'b0;
        end else begin
          data_d = '0;
          zero_d = 1'b0;
          err_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Operand registers feed the ULA directly, so they are valid throughout EXEC.
  assign ula_a     = a_q;
  assign ula_b     = b_q;
  assign ula_ctrl  = op_q;
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a behavioural ULA model on the ula_* port.
module tb_ula_arbiter;
  import ula_pkg::*;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [7:0]   req_op;
  logic [W-1:0] rsp_data, ula_a, ula_b, ula_result;
  logic         rsp_zero, rsp_err, busy;
  logic [3:0]   ula_ctrl;
  logic [1:0]   dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Clock / reset
  always #5 clk = ~clk;

  ula_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy),
    .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl),
    .ula_result(ula_result), .dbg_state(dbg_state)
  );

  // Illegal codes return a non-zero pattern so a leak into rsp_data is visible.
  always_comb begin
    ula_result = 9'h155;
    case (ula_ctrl)
      4'b0000: ula_result = ula_a & ula_b;
      4'b0001: ula_result = ula_a | ula_b;
      4'b0010: ula_result = ula_a + ula_b;
      4'b0011: ula_result = ~(ula_a | ula_b);
      4'b0110: ula_result = ula_a - ula_b;
      4'b0111: ula_result = {8'd0, (ula_a < ula_b)};
      default: ula_result = 9'h155;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_op[r*4 +: 4] = op;
    req_valid[r] = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"}, {30'd0, req_ready}, 0);
    check({tag, " rsp_valid"}, {30'd0, rsp_valid}, 0);
    check({tag, " rsp_data"}, {23'd0, rsp_data}, 0);
    check({tag, " zero/err/busy"}, {29'd0, rsp_zero, rsp_err, busy}, 0);
    check({tag, " ula_a"}, {23'd0, ula_a}, 0);
    check({tag, " ula_b"}, {23'd0, ula_b}, 0);
    check({tag, " ula_ctrl"}, {28'd0, ula_ctrl}, 0);
  endtask

  // Full single-requester transaction with rsp_ready held high; entered in IDLE.
  task automatic do_op(input string tag, input int r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [3:0] op,
                       input logic [W-1:0] exp_data, input logic exp_zero, input logic exp_err);
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    rsp_ready = 2'b11;
    set_req(r, a, b, op);
    #1;
    check({tag, " req_ready"}, {30'd0, req_ready}, {30'd0, oh});
    step();
    req_valid = 2'b00;
    check({tag, " exec ula_ctrl/busy"}, {27'd0, ula_ctrl, busy}, {27'd0, op, 1'b1});
    check({tag, " exec rsp_valid"}, {30'd0, rsp_valid}, 0);
    step();
    check({tag, " rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh});
    check({tag, " rsp_data"}, {23'd0, rsp_data}, {23'd0, exp_data});
    check({tag, " zero/err"}, {30'd0, rsp_zero, rsp_err}, {30'd0, exp_zero, exp_err});
    step();
    check({tag, " done"}, {30'd0, rsp_valid, busy}, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    do_op("add100+27", 0, 9'd100, 9'd27, OP_ADD, 9'd127, 1'b0, 1'b0);
    do_op("sub5-5", 1, 9'd5, 9'd5, OP_SUB, 9'd0, 1'b1, 1'b0);
    do_op("add1ff+1", 0, 9'h1FF, 9'd1, OP_ADD, 9'd0, 1'b1, 1'b0);
    do_op("slt_pre", 1, 9'd3, 9'd7, OP_SLT, 9'd1, 1'b0, 1'b0);

    // Both requesters valid continuously: last grant was 1, so 0,1,0,1.
    rsp_ready = 2'b11;
    set_req(0, 9'h0F0, 9'h0FF, OP_AND);
    set_req(1, 9'd3, 9'd7, OP_SLT);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr req_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      step();
      check("rr rsp_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check("rr rsp_data", {23'd0, rsp_data}, (i % 2 == 0) ? 32'h0F0 : 32'd1);
      step();
    end
    req_valid = 2'b00;

    do_op("illegal", 0, 9'd5, 9'd3, 4'b1010, 9'd0, 1'b0, 1'b1);
    do_op("or_after_err", 0, 9'd5, 9'd3, OP_OR, 9'd7, 1'b0, 1'b0);

    // Response back-pressure with a pending req1.
    rsp_ready = 2'b00;
    set_req(0, 9'd1, 9'd2, OP_ADD);
    #1;
    check("stall accept", {30'd0, req_ready}, 1);
    step();
    req_valid = 2'b00;
    set_req(1, 9'h1FF, 9'h00F, OP_AND);
    step();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check("stall rsp_valid", {30'd0, rsp_valid}, 1);
      check("stall rsp_data", {23'd0, rsp_data}, 3);
      check("stall req_ready/busy", {29'd0, req_ready, busy}, {29'd0, 2'b00, 1'b1});
      step();
    end
    rsp_ready = 2'b01;
    step();
    check("post stall grant1", {29'd0, req_ready, rsp_valid[0]}, {29'd0, 2'b10, 1'b0});
    step();
    req_valid = 2'b00;
    step();
    check("req1 rsp_valid", {30'd0, rsp_valid}, 2);
    check("req1 rsp_data", {23'd0, rsp_data}, 9'h00F);
    rsp_ready = 2'b11;
    step();

    // Reset mid-EXEC; pre-reset last grant is 0, so both-valid picks 1 first.
    do_op("pre_rst", 0, 9'd2, 9'd2, OP_ADD, 9'd4, 1'b0, 1'b0);
    set_req(0, 9'd4, 9'd4, OP_ADD);
    set_req(1, 9'd1, 9'd1, OP_ADD);
    #1;
    check("pre_rst grant", {30'd0, req_ready}, 2);
    step();
    check("pre_rst busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_exec");
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst no rsp", {30'd0, rsp_valid}, 0);
    end
    rst = 1'b0;
    #1;
    check("post_rst grant0", {30'd0, req_ready}, 1);
    step();
    req_valid = 2'b00;
    step();
    check("post_rst rsp_valid", {30'd0, rsp_valid}, 1);
    check("post_rst rsp_data", {23'd0, rsp_data}, 8);
    step();
    check("post_rst idle", {30'd0, rsp_valid, busy}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
